// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// ----------------
// Self-timed boot loader for the pipeline's instruction memory. It holds the
// core in reset and clears the memory. It then streams program words in over
// a valid/ready interface, optionally pads the unused tail with PAD_WORD, and
// releases the core HOLD_CYCLES cycles after the final write is issued.
// Reloading is possible from RUN or ERR by pulsing start.
//
// Ports:
//   clk, reset         single rising-edge clock, synchronous active-high reset
//   start              begin a load (honoured in IDLE, RUN and ERR only)
//   pad_en             sampled on the s_last handshake: pad remaining words
//   s_valid/s_ready    stream handshake; s_data is the word, s_last ends program
//   instruction_reset  one-cycle memory clear pulse
//   write_signal       memory write enable, with write_address/instruction_write
//   core_reset         pipeline reset, low only in RUN
//   done               high in RUN
//   overflow           sticky: a word arrived with the memory already full
//   word_count         stream words accepted since the last start (no pads)
module imem_boot_loader #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DEPTH       = 256,
  parameter logic [DATA_W-1:0] PAD_WORD    = '0,
  parameter int unsigned       HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pad_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              instruction_reset,
  output logic              write_signal,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] instruction_write,
  output logic              core_reset,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_PAD   = 3'd3,
    S_HOLD  = 3'd4,
    S_RUN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // Address is one bit wider than the memory index so "full" (== DEPTH) is
  // representable without wrapping.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_A   = (ADDR_W + 1)'(1);
  localparam int unsigned     HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST_C = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE_C  = HOLD_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                s_ready_q, s_ready_d;
  logic                instruction_reset_q, instruction_reset_d;
  logic                write_signal_q, write_signal_d;
  logic [ADDR_W-1:0]   write_address_q, write_address_d;
  logic [DATA_W-1:0]   instruction_write_q, instruction_write_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                handshake;

  // s_ready is registered, so the handshake uses the value the source saw.
  assign handshake = s_valid & s_ready_q;

  // Next-state, counter and next-output logic.
  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    hold_cnt_d          = hold_cnt_q;
    word_count_d        = word_count_q;
    overflow_d          = overflow_q;
    instruction_reset_d = 1'b0;
    write_signal_d      = 1'b0;
    write_address_d     = write_address_q;
    instruction_write_d = instruction_write_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d             = S_CLEAR;
          addr_d              = '0;
          word_count_d        = '0;
          overflow_d          = 1'b0;
          instruction_reset_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (handshake) begin
          if (addr_q < DEPTH_C) begin
            write_signal_d      = 1'b1;
            write_address_d     = addr_q[ADDR_W-1:0];
            instruction_write_d = s_data;
            addr_d              = addr_q + ONE_A;
            word_count_d        = word_count_q + ONE_A;
            if (s_last) begin
              // Pad only if at least one address remains after this word.
              if (pad_en && (addr_d < DEPTH_C)) begin
                state_d = S_PAD;
              end else begin
                state_d    = S_HOLD;
                hold_cnt_d = '0;
              end
            end else begin
              state_d = S_LOAD;
            end
          end else begin
            // Memory already full: drop the word and flag it.
            overflow_d = 1'b1;
            state_d    = S_ERR;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PAD: begin
        write_signal_d      = 1'b1;
        write_address_d     = addr_q[ADDR_W-1:0];
        instruction_write_d = PAD_WORD;
        addr_d              = addr_q + ONE_A;
        if (addr_q == LAST_C) begin
          state_d    = S_HOLD;
          hold_cnt_d = '0;
        end else begin
          state_d = S_PAD;
        end
      end
      S_HOLD: begin
        // HOLD is entered on the final write's edge; leave after HOLD_CYCLES edges.
        if (hold_cnt_q == HOLD_LAST_C) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE_C;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Level outputs follow the state being entered so they are registered
    // alongside it.
    s_ready_d    = (state_d == S_LOAD);
    core_reset_d = (state_d != S_RUN);
    done_d       = (state_d == S_RUN);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= S_IDLE;
      addr_q              <= '0;
      hold_cnt_q          <= '0;
      s_ready_q           <= 1'b0;
      instruction_reset_q <= 1'b0;
      write_signal_q      <= 1'b0;
      write_address_q     <= '0;
      instruction_write_q <= '0;
      core_reset_q        <= 1'b1;
      done_q              <= 1'b0;
      overflow_q          <= 1'b0;
      word_count_q        <= '0;
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      hold_cnt_q          <= hold_cnt_d;
      s_ready_q           <= s_ready_d;
      instruction_reset_q <= instruction_reset_d;
      write_signal_q      <= write_signal_d;
      write_address_q     <= write_address_d;
      instruction_write_q <= instruction_write_d;
      core_reset_q        <= core_reset_d;
      done_q              <= done_d;
      overflow_q          <= overflow_d;
      word_count_q        <= word_count_d;
    end
  end

  assign s_ready           = s_ready_q;
  assign instruction_reset = instruction_reset_q;
  assign write_signal      = write_signal_q;
  assign write_address     = write_address_q;
  assign instruction_write = instruction_write_q;
  assign core_reset        = core_reset_q;
  assign done              = done_q;
  assign overflow          = overflow_q;
  assign word_count        = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader (DEPTH=8, ADDR_W=3, PAD_WORD=0x13, HOLD=2).
// A behavioural model tracks the loader's phase, address and counts, and a
// memory image; DUT outputs are compared every cycle, 1 time unit after the
// rising edge.
module tb_imem_boot_loader;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam logic [31:0] PADW = 32'h13;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_PAD = 3,
                 P_HOLD = 4, P_RUN = 5, P_ERR = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, pad_en = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, instruction_reset, write_signal, core_reset, done, overflow;
  logic [AW-1:0] write_address;
  logic [DW-1:0] instruction_write;
  logic [AW:0]   word_count;

  imem_boot_loader #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PAD_WORD(PADW), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pad_en(pad_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .instruction_reset(instruction_reset), .write_signal(write_signal),
    .write_address(write_address), .instruction_write(instruction_write),
    .core_reset(core_reset), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  // model state
  int          m_phase = P_IDLE, m_addr = 0, m_cnt = 0, m_hold = 0;
  bit          m_ovf = 0, m_wr = 0, m_irst = 0;
  int          m_waddr = 0;
  logic [31:0] m_wdata = '0;
  logic [31:0] exp_mem [DEPTH];
  logic [31:0] dut_mem [DEPTH];
  int          dut_wr_cnt = 0, last_wr_cyc = 0;
  logic        prev_core_reset = 1'b1;
  logic [31:0] sent [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic issue(input int a, input logic [31:0] d);
    m_wr = 1;
    m_waddr = a;
    m_wdata = d;
    exp_mem[a] = d;
  endtask

  task automatic model_edge(input bit hs);
    m_wr = 0;
    m_irst = 0;
    if (reset) begin
      m_phase = P_IDLE; m_addr = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      case (m_phase)
        P_IDLE, P_RUN, P_ERR:
          if (start) begin
            m_phase = P_CLEAR; m_irst = 1; m_addr = 0; m_cnt = 0; m_ovf = 0;
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
          end
        P_CLEAR: m_phase = P_LOAD;
        P_LOAD:
          if (hs) begin
            if (m_addr < DEPTH) begin
              issue(m_addr, s_data);
              m_addr++;
              m_cnt++;
              if (s_last) begin
                if (pad_en && m_addr < DEPTH) m_phase = P_PAD;
                else begin m_phase = P_HOLD; m_hold = HOLD; end
              end
            end else begin
              m_ovf = 1;
              m_phase = P_ERR;
            end
          end
        P_PAD: begin
          issue(m_addr, PADW);
          m_addr++;
          if (m_addr == DEPTH) begin m_phase = P_HOLD; m_hold = HOLD; end
        end
        P_HOLD: begin
          m_hold--;
          if (m_hold == 0) m_phase = P_RUN;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("s_ready", {63'd0, s_ready}, {63'd0, m_phase == P_LOAD});
    chk("core_reset", {63'd0, core_reset}, {63'd0, m_phase != P_RUN});
    chk("done", {63'd0, done}, {63'd0, m_phase == P_RUN});
    chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    chk("instruction_reset", {63'd0, instruction_reset}, {63'd0, m_irst});
    chk("write_signal", {63'd0, write_signal}, {63'd0, m_wr});
    if (m_wr) begin
      chk("write_address", 64'(write_address), 64'(m_waddr));
      chk("instruction_write", 64'(instruction_write), 64'(m_wdata));
    end
    chk("word_count", 64'(word_count), 64'(m_cnt));
    // capture what the DUT does to a memory, for image comparisons
    if (instruction_reset === 1'b1) begin
      for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'h0;
      dut_wr_cnt = 0;
    end
    if (write_signal === 1'b1) begin
      dut_mem[write_address] = instruction_write;
      dut_wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (prev_core_reset === 1'b1 && core_reset === 1'b0)
      chk("release_latency", 64'(cyc - last_wr_cyc), 64'(HOLD));
    prev_core_reset = core_reset;
  endtask

  task automatic step();
    bit hs;
    hs = s_valid && (m_phase == P_LOAD);
    @(posedge clk);
    cyc++;
    model_edge(hs);
    #1;
    compare_all();
  endtask

  task automatic settle();
    int g;
    g = 0;
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    while (m_phase != P_RUN && m_phase != P_ERR && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) note_fail("settle_timeout");
  endtask

  task automatic compare_image();
    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), 64'(dut_mem[i]), 64'(exp_mem[i]));
  endtask

  // start a load of len words; gap_pct = chance of s_valid low per cycle
  task automatic do_load(input int len, input bit pad, input int gap_pct, input bit noise);
    int idx, g;
    bit hs;
    for (int i = 0; i < len; i++) sent[i] = $urandom;
    start = 1'b1;
    step();
    start = 1'b0;
    idx = 0; g = 0;
    while (idx < len && m_phase != P_ERR && g < 400) begin
      s_valid = ($urandom_range(99) >= gap_pct);
      s_data  = sent[idx];
      s_last  = (idx == len - 1);
      pad_en  = (idx == len - 1) ? pad : 1'($urandom_range(1));
      start   = noise ? 1'($urandom_range(7) == 0) : 1'b0;
      hs = s_valid && (m_phase == P_LOAD);
      step();
      if (hs) idx++;
      g++;
    end
    if (g >= 400) note_fail("load_timeout");
    settle();
  endtask

  initial begin
    logic [5:0] pat;
    int g;
    for (int i = 0; i < DEPTH; i++) begin exp_mem[i] = 32'h0; dut_mem[i] = 32'h0; end

    // reset
    reset = 1'b1;
    step();
    step();
    chk("reset_core_reset", {63'd0, core_reset}, 64'd1);
    chk("reset_write_signal", {63'd0, write_signal}, 64'd0);
    reset = 1'b0;
    step();

    // basic load: 0x11, 0x22, 0x33, no pad
    start = 1'b1;
    step();
    chk("basic_irst", {63'd0, instruction_reset}, 64'd1);
    start = 1'b0;
    step();
    chk("basic_ready", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b1; pad_en = 1'b0;
    s_data = 32'h11; s_last = 1'b0; step();
    s_data = 32'h22; step();
    s_data = 32'h33; s_last = 1'b1; step();
    chk("basic_addr2", 64'(write_address), 64'd2);
    chk("basic_data2", 64'(instruction_write), 64'h33);
    chk("basic_count", 64'(word_count), 64'd3);
    chk("model_count", 64'(m_cnt), 64'd3);
    s_valid = 1'b0; s_last = 1'b0;
    step();
    chk("basic_hold1", {63'd0, core_reset}, 64'd1);
    step();
    chk("basic_release", {63'd0, core_reset}, 64'd0);
    chk("basic_done", {63'd0, done}, 64'd1);
    chk("basic_mem1", 64'(dut_mem[1]), 64'h22);

    // padding: 2 words with pad_en=1
    do_load(2, 1'b1, 0, 1'b0);
    chk("pad_count", 64'(word_count), 64'd2);
    chk("pad_writes", 64'(dut_wr_cnt), 64'd8);
    for (int i = 2; i < DEPTH; i++) chk("pad_word", 64'(dut_mem[i]), 64'h13);
    compare_image();

    // overflow: 9 words into 8
    do_load(9, 1'b0, 0, 1'b0);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_writes", 64'(dut_wr_cnt), 64'd8);
    chk("ovf_core_reset", {63'd0, core_reset}, 64'd1);
    chk("ovf_count", 64'(word_count), 64'd8);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    step();

    // gapped stream: valid 1,0,0,1,0,1(last)
    pat = 6'b101001;
    pad_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_valid = pat[k];
      s_data  = 32'hA0 + 32'(k);
      s_last  = (k == 5);
      step();
    end
    settle();
    chk("gap_writes", 64'(dut_wr_cnt), 64'd3);
    chk("gap_mem0", 64'(dut_mem[0]), 64'hA0);
    chk("gap_mem1", 64'(dut_mem[1]), 64'hA3);
    chk("gap_mem2", 64'(dut_mem[2]), 64'hA5);

    // restart from RUN
    start = 1'b1;
    step();
    chk("restart_core_reset", {63'd0, core_reset}, 64'd1);
    chk("restart_irst", {63'd0, instruction_reset}, 64'd1);
    chk("restart_count", 64'(word_count), 64'd0);
    do_load(3, 1'b0, 30, 1'b0);
    chk("restart_mem0", 64'(dut_mem[0]), 64'(sent[0]));
    compare_image();

    // reset in the middle of PAD
    start = 1'b1; step(); start = 1'b0; step();
    s_valid = 1'b1; s_data = 32'hBEEF; s_last = 1'b0; step();
    s_data = 32'hCAFE; s_last = 1'b1; pad_en = 1'b1; step();
    s_valid = 1'b0; s_last = 1'b0;
    g = 0;
    while (!(m_phase == P_PAD && m_addr == 4) && g < 20) begin step(); g++; end
    if (g >= 20) note_fail("pad_reach_timeout");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_write_signal", {63'd0, write_signal}, 64'd0);
    chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
    chk("rst_count", 64'(word_count), 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    repeat (3) step();
    chk("rst_stays_idle", {63'd0, core_reset}, 64'd1);

    // randomized loads, some with noise on start
    for (int t = 0; t < 30; t++) begin
      do_load($urandom_range(10, 1), 1'($urandom_range(1)), $urandom_range(60), 1'($urandom_range(1)));
      compare_image();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
